prga_fifo_param: RTL and testbench

Parametrised successor to the fixed-depth FIFO. A single synchronous FIFO with configurable data width, power-of-two depth and read mode (lookahead or non-lookahead). Adds almost-full/almost-empty thresholds and an occupancy count. Sits between producer/consumer stages in PRGA fabric I/O and configuration paths, and directly replaces a FIFO plus lookahead-buffer pair.

---
 rtl/prga_fifo_param.sv | 112 +++++++++++
 tb/tb_prga_fifo_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_fifo_param.sv
// Parametrised synchronous FIFO with lookahead/registered read modes, threshold flags and count.
// Optional sticky overflow/underflow flags are enabled by defining PRGA_FIFO_ERROR_FLAGS_EN.
module prga_fifo_param #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned LOOKAHEAD     = 0,
  parameter int unsigned AFULL_THRESH  = 2**DEPTH_LOG2 - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] One       = 1;
  localparam logic [DEPTH_LOG2:0] AfullThr  = AFULL_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AemptyThr = AEMPTY_THRESH[DEPTH_LOG2:0];

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DEPTH_LOG2:0]   wptr_q, rptr_q, count_q;
  logic                  wr_acc, rd_acc;

  // Extra MSB on each pointer distinguishes full from empty when low bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  assign count        = count_q;
  assign almost_full  = (count_q >= AfullThr);
  assign almost_empty = (count_q <= AemptyThr);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + One;
      if (rd_acc) rptr_q <= rptr_q + One;
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + One;
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - One;
      end
    end
  end

  generate
    if (LOOKAHEAD != 0) begin : g_lookahead
      // Gate with empty so dout reads 0 after reset rather than uninitialised storage.
      assign dout = empty ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem_q[rptr_q[DEPTH_LOG2-1:0]];
        end
      end
      assign dout = dout_q;
    end
  endgenerate

`ifdef PRGA_FIFO_ERROR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr && full)  overflow_q  <= 1'b1;
      if (rd && empty) underflow_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && wr && full)  $display("prga_fifo_param warning: write while full dropped");
    if (rst && rd && empty) $display("prga_fifo_param warning: read while empty ignored");
  end
`endif

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prga_fifo_param.sv
// Directed bench for prga_fifo_param: a registered-read and a lookahead instance share stimulus.
module tb_prga_fifo_param;

`ifdef PRGA_FIFO_ERROR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] din = '0;

  logic       full0, afull0, empty0, aempty0, ovf0, unf0;
  logic [7:0] dout0;
  logic [2:0] count0;
  logic       full1, afull1, empty1, aempty1, ovf1, unf1;
  logic [7:0] dout1;
  logic [2:0] count1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prga_fifo_param #(
    .DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full0), .almost_full(afull0),
    .rd(rd), .dout(dout0), .empty(empty0), .almost_empty(aempty0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  prga_fifo_param #(
    .DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full1), .almost_full(afull1),
    .rd(rd), .dout(dout1), .empty(empty1), .almost_empty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({count0, empty0, full0, aempty0, afull0, dout0} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00})
    begin
      n_err++;
      $display("FAIL reset0: cnt=%0d e=%b f=%b ae=%b af=%b dout=%h, want 0 1 0 1 0 00",
               count0, empty0, full0, aempty0, afull0, dout0);
    end
    n_vec++;
    if ({count1, empty1, full1, dout1, ovf0, unf0, ovf1, unf1} !== {3'd0, 1'b1, 1'b0, 8'h00, 4'b0})
    begin
      n_err++;
      $display("FAIL reset1: cnt=%0d e=%b f=%b dout=%h flags=%b%b%b%b, want 0 1 0 00 0000",
               count1, empty1, full1, dout1, ovf0, unf0, ovf1, unf1);
    end
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h5A, 8'hF6, 8'h09, 8'hC4};
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = vals[i];
      cycle();
      n_vec++;
      if ({count0, aempty0, afull0, full0, dout1} !==
          {3'(i + 1), (i + 1) <= 1, (i + 1) >= 3, i == 3, 8'h5A}) begin
        n_err++;
        $display("FAIL fill[%0d]: cnt=%0d ae=%b af=%b f=%b head=%h, want %0d %b %b %b 5a",
                 i, count0, aempty0, afull0, full0, dout1, i + 1, (i + 1) <= 1, (i + 1) >= 3,
                 i == 3);
      end
    end
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      cycle();
      n_vec++;
      if ({dout0, count0, empty0} !== {vals[i], 3'(3 - i), i == 3}) begin
        n_err++;
        $display("FAIL drain[%0d]: dout=%h cnt=%0d e=%b, want %h %0d %b",
                 i, dout0, count0, empty0, vals[i], 3 - i, i == 3);
      end
      n_vec++;
      if (dout1 !== ((i == 3) ? 8'h00 : vals[i + 1])) begin
        n_err++;
        $display("FAIL drain_head[%0d]: dout=%h, want %h",
                 i, dout1, (i == 3) ? 8'h00 : vals[i + 1]);
      end
    end
    // Read while empty: ignored, registered dout holds.
    cycle();
    rd = 1'b0;
    n_vec++;
    if ({dout0, count0, empty0, unf0, ovf0} !== {8'hC4, 3'd0, 1'b1, ErrEn, 1'b0}) begin
      n_err++;
      $display("FAIL rd_empty: dout=%h cnt=%0d e=%b unf=%b ovf=%b, want c4 0 1 %b 0",
               dout0, count0, empty0, unf0, ovf0, ErrEn);
    end
  endtask

  task automatic test_lookahead();
    wr = 1'b1; din = 8'h81;
    cycle();
    wr = 1'b0;
    n_vec++;
    if ({empty1, dout1, empty0, dout0} !== {1'b0, 8'h81, 1'b0, 8'hC4}) begin
      n_err++;
      $display("FAIL la_write: e1=%b d1=%h e0=%b d0=%h, want 0 81 0 c4",
               empty1, dout1, empty0, dout0);
    end
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    n_vec++;
    if ({empty1, empty0, dout0, count1} !== {1'b1, 1'b1, 8'h81, 3'd0}) begin
      n_err++;
      $display("FAIL la_read: e1=%b e0=%b d0=%h c1=%0d, want 1 1 81 0",
               empty1, empty0, dout0, count1);
    end
  endtask

  task automatic test_full_wr_rd();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = vals[i];
      cycle();
    end
    n_vec++;
    if ({full0, count0, ovf0} !== {1'b1, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL full_pre: f=%b cnt=%0d ovf=%b, want 1 4 0", full0, count0, ovf0);
    end
    wr = 1'b1; rd = 1'b1; din = 8'hE2;
    cycle();
    wr = 1'b0; rd = 1'b0;
    n_vec++;
    if ({count0, full0, dout0, ovf0, ovf1} !== {3'd3, 1'b0, 8'h11, ErrEn, ErrEn}) begin
      n_err++;
      $display("FAIL full_wr_rd: cnt=%0d f=%b dout=%h ovf=%b%b, want 3 0 11 %b%b",
               count0, full0, dout0, ovf0, ovf1, ErrEn, ErrEn);
    end
    for (int i = 1; i < 4; i++) begin
      rd = 1'b1;
      cycle();
      n_vec++;
      if (dout0 !== vals[i]) begin
        n_err++;
        $display("FAIL full_drain[%0d]: dout=%h, want %h", i, dout0, vals[i]);
      end
    end
    rd = 1'b0;
    n_vec++;
    if ({empty0, ovf0} !== {1'b1, ErrEn}) begin
      n_err++;
      $display("FAIL full_sticky: e=%b ovf=%b, want 1 %b", empty0, ovf0, ErrEn);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    wr = 1'b1; din = 8'd0;
    cycle();
    for (int i = 1; i < 20; i++) begin
      wr = 1'b1; rd = 1'b1; din = 8'(i);
      cycle();
      n_vec++;
      if ({dout0, count0, full0, dout1} !== {8'(i - 1), 3'd1, 1'b0, 8'(i)}) begin
        n_err++;
        bad++;
        $display("FAIL stream[%0d]: d0=%h cnt=%0d f=%b d1=%h, want %h 1 0 %h",
                 i, dout0, count0, full0, dout1, 8'(i - 1), 8'(i));
      end
    end
    wr = 1'b0; rd = 1'b1;
    cycle();
    rd = 1'b0;
    n_vec++;
    if ({dout0, empty0, count0} !== {8'd19, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL stream_last: d0=%h e=%b cnt=%0d, want 13 1 0", dout0, empty0, count0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 8'hA1 + 8'(i);
      cycle();
    end
    n_vec++;
    if ({count0, dout0} !== {3'd3, 8'd19}) begin
      n_err++;
      $display("FAIL arst_pre: cnt=%0d dout=%h, want 3 13", count0, dout0);
    end
    rd = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({count0, empty0, dout0, count1, empty1, dout1} !==
        {3'd0, 1'b1, 8'h00, 3'd0, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL arst_mid: c0=%0d e0=%b d0=%h c1=%0d e1=%b d1=%h, want 0 1 00 0 1 00",
               count0, empty0, dout0, count1, empty1, dout1);
    end
    wr = 1'b0;
    #1;
    rst = 1'b1;
    cycle();
    rd = 1'b0;
    n_vec++;
    if ({count0, empty0, dout0, unf0, ovf0, unf1} !== {3'd0, 1'b1, 8'h00, ErrEn, 1'b0, ErrEn})
    begin
      n_err++;
      $display("FAIL arst_rd: cnt=%0d e=%b dout=%h unf=%b ovf=%b unf1=%b, want 0 1 00 %b 0 %b",
               count0, empty0, dout0, unf0, ovf0, unf1, ErrEn, ErrEn);
    end
    n_vec++;
    if ({afull1, aempty1, full1} !== 3'b010) begin
      n_err++;
      $display("FAIL arst_flags1: af=%b ae=%b f=%b, want 0 1 0", afull1, aempty1, full1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_lookahead();
    test_full_wr_rd();
    test_stream();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want finish before 100000");
    $fatal(1);
  end

endmodule
